// File: rtl/oam_dma_seq.sv
// OAM DMA sequencer: $4014-triggered 256-byte copy to $2004 with DMC cycle stealing.
// Bus outputs are registered from the next state so they line up with the state they describe.
module oam_dma_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_wr,
    input  logic [7:0]  reg_data,
    input  logic        cpu_rw,
    input  logic        dmc_req,
    input  logic [15:0] dmc_addr,
    input  logic [7:0]  din,
    output logic        halt,
    output logic [1:0]  bus_sel,
    output logic [15:0] addr,
    output logic [7:0]  dout,
    output logic        rw,
    output logic        dmc_ack,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE, S_HALT, S_ALIGN, S_READ, S_WRITE, S_DMC
    } state_t;

    state_t      state_q, state_d;
    logic        parity_q;
    logic        pend_q;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  latch_q, latch_d;
    logic        halt_q, busy_q, ack_q, done_q, rw_q;
    logic [1:0]  sel_q;
    logic [15:0] addr_q;
    logic [7:0]  dout_q;

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        latch_d = latch_q;
        unique case (state_q)
            S_IDLE: begin
                if (reg_wr) begin
                    state_d = S_HALT;
                    page_d  = reg_data;
                    idx_d   = 8'h00;
                end else if (dmc_req) begin
                    state_d = S_HALT;
                end
            end
            S_HALT: if (cpu_rw) state_d = S_ALIGN;
            S_ALIGN: begin
                // parity=1 here means the following cycle is a get cycle
                if (parity_q) begin
                    if (dmc_req)     state_d = S_DMC;
                    else if (pend_q) state_d = S_READ;
                    else             state_d = S_IDLE;
                end
            end
            S_READ: begin
                state_d = S_WRITE;
                latch_d = din;
            end
            S_WRITE: begin
                idx_d = idx_q + 8'd1;
                if (idx_q == 8'hFF) state_d = S_IDLE;
                else if (dmc_req)   state_d = S_DMC;
                else                state_d = S_READ;
            end
            S_DMC:   state_d = S_ALIGN;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            parity_q <= 1'b0;
            pend_q   <= 1'b0;
            page_q   <= 8'h00;
            idx_q    <= 8'h00;
            latch_q  <= 8'h00;
            halt_q   <= 1'b0;
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
            done_q   <= 1'b0;
            sel_q    <= 2'd0;
            addr_q   <= 16'h0000;
            dout_q   <= 8'h00;
            rw_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            parity_q <= ~parity_q;
            page_q   <= page_d;
            idx_q    <= idx_d;
            latch_q  <= latch_d;
            if (state_q == S_IDLE && reg_wr)
                pend_q <= 1'b1;
            else if (state_q == S_WRITE && idx_q == 8'hFF)
                pend_q <= 1'b0;
            halt_q <= (state_d != S_IDLE);
            busy_q <= (state_d != S_IDLE);
            ack_q  <= (state_d == S_DMC);
            done_q <= (state_d == S_WRITE) && (idx_d == 8'hFF);
            unique case (state_d)
                S_READ: begin
                    sel_q  <= 2'd1;
                    addr_q <= {page_d, idx_d};
                    rw_q   <= 1'b1;
                end
                S_WRITE: begin
                    sel_q  <= 2'd1;
                    addr_q <= 16'h2004;
                    rw_q   <= 1'b0;
                    dout_q <= latch_d;
                end
                S_DMC: begin
                    sel_q  <= 2'd2;
                    addr_q <= dmc_addr;
                    rw_q   <= 1'b1;
                end
                S_IDLE: begin
                    sel_q  <= 2'd0;
                    addr_q <= 16'h0000;
                    rw_q   <= 1'b1;
                    dout_q <= 8'h00;
                end
                default: begin
                    sel_q  <= 2'd0;
                    addr_q <= 16'h0000;
                    rw_q   <= 1'b1;
                end
            endcase
        end
    end

    assign halt    = halt_q;
    assign busy    = busy_q;
    assign dmc_ack = ack_q;
    assign done    = done_q;
    assign bus_sel = sel_q;
    assign addr    = addr_q;
    assign dout    = dout_q;
    assign rw      = rw_q;

endmodule

// File: tb/tb_oam_dma_seq.sv
// Scoreboard bench for oam_dma_seq: stimulus queues expected bus cycles,
// a negedge monitor pops and compares every DMA-driven cycle.
module tb_oam_dma_seq;

    logic        clk = 1'b0;
    logic        rst, reg_wr, cpu_rw, dmc_req;
    logic [7:0]  reg_data, din;
    logic [15:0] dmc_addr;
    logic        halt, rw, dmc_ack, busy, done;
    logic [1:0]  bus_sel;
    logic [15:0] addr;
    logic [7:0]  dout;

    typedef struct {
        logic [1:0]  sel;
        logic [15:0] addr;
        logic        rw;
        logic [7:0]  dout;
        logic        chk_d;
        logic        ack;
        logic        done;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   cyc = 0;

    oam_dma_seq dut (
        .clk(clk), .rst(rst), .reg_wr(reg_wr), .reg_data(reg_data),
        .cpu_rw(cpu_rw), .dmc_req(dmc_req), .dmc_addr(dmc_addr),
        .din(din), .halt(halt), .bus_sel(bus_sel), .addr(addr),
        .dout(dout), .rw(rw), .dmc_ack(dmc_ack), .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    // memory model: page bytes read back as low address byte ^ A5
    always_comb din = (bus_sel == 2'd1 && rw) ? (addr[7:0] ^ 8'hA5) : 8'h00;

    // cycle index since reset; its LSB is the expected get/put parity
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act,
                           input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d want %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic push_rd(input logic [7:0] pg, input logic [7:0] i);
        exp_t e;
        e = '{2'd1, {pg, i}, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        sb.push_back(e);
    endtask

    task automatic push_wr(input logic [7:0] i);
        exp_t e;
        e = '{2'd1, 16'h2004, 1'b0, i ^ 8'hA5, 1'b1, 1'b0, i == 8'hFF};
        sb.push_back(e);
    endtask

    task automatic push_dmc(input logic [15:0] a);
        exp_t e;
        e = '{2'd2, a, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
        sb.push_back(e);
    endtask

    task automatic wait_until(input string nm, input int kind,
                              input logic [15:0] a);
        int n;
        logic hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 2000) begin
            case (kind)
                0: hit = (bus_sel == 2'd1 && rw && addr == a);
                1: hit = dmc_ack;
                default: hit = !busy;
            endcase
            if (!hit) begin
                n++;
                @(negedge clk);
            end
        end
        if (!hit) begin
            total++;
            bad++;
            $display("FAIL %s: got timeout want event", nm);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done) done_cnt++;
        chk("sel_not3", {31'b0, bus_sel == 2'd3}, 32'd0);
        if (bus_sel != 2'd0) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_bus: got sel=%0d addr=%h want none",
                         bus_sel, addr);
            end else begin
                e = sb.pop_front();
                chk("sel", {30'b0, bus_sel}, {30'b0, e.sel});
                chk("addr", {16'b0, addr}, {16'b0, e.addr});
                chk("rw", {31'b0, rw}, {31'b0, e.rw});
                chk("ack", {31'b0, dmc_ack}, {31'b0, e.ack});
                chk("done", {31'b0, done}, {31'b0, e.done});
                if (e.chk_d) chk("dout", {24'b0, dout}, {24'b0, e.dout});
                if (bus_sel == 2'd1 && rw)
                    chk("read_on_get", cyc % 2, 0);
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1; reg_wr = 1'b0; reg_data = 8'h00; cpu_rw = 1'b1;
        dmc_req = 1'b0; dmc_addr = 16'h0000;
        repeat (2) @(negedge clk);
        chk("rst_halt", {31'b0, halt}, 0);
        chk("rst_sel", {30'b0, bus_sel}, 0);
        chk("rst_addr", {16'b0, addr}, 0);
        chk("rst_dout", {24'b0, dout}, 0);
        chk("rst_rw", {31'b0, rw}, 1);
        chk("rst_ack", {31'b0, dmc_ack}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        rst = 1'b0;
        @(negedge clk);

        // baseline full transfer from page $02
        for (int i = 0; i < 256; i++) begin
            push_rd(8'h02, i[7:0]);
            push_wr(i[7:0]);
        end
        reg_wr = 1'b1; reg_data = 8'h02;
        @(negedge clk);
        reg_wr = 1'b0;
        n = 0;
        while (busy && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk_rng("base_cycles", n, 514, 515);
        chk("base_done_cnt", done_cnt, 1);
        chk("base_sb_empty", sb.size(), 0);
        chk("idle_sel", {30'b0, bus_sel}, 0);
        chk("idle_rw", {31'b0, rw}, 1);

        // CPU write stall, DMC steal at idx $10, ignored $4014 write at idx $40
        for (int i = 0; i < 256; i++) begin
            push_rd(8'h02, i[7:0]);
            push_wr(i[7:0]);
            if (i == 16) push_dmc(16'hC000);
        end
        reg_wr = 1'b1; reg_data = 8'h02; cpu_rw = 1'b0;
        @(negedge clk);
        reg_wr = 1'b0;
        n = 0;
        while (bus_sel == 2'd0 && n < 50) begin
            chk("stall_halt", {31'b0, halt}, 1);
            n++;
            if (n >= 4) cpu_rw = 1'b1;
            @(negedge clk);
        end
        cpu_rw = 1'b1;
        chk_rng("stall_pre_cycles", n, 5, 6);
        wait_until("wait_rd_0210", 0, 16'h0210);
        @(negedge clk);
        dmc_req = 1'b1; dmc_addr = 16'hC000;
        wait_until("wait_ack", 1, 16'h0000);
        dmc_req = 1'b0;
        @(negedge clk);
        chk("align_after_dmc_halt", {31'b0, halt}, 1);
        chk("align_after_dmc_sel", {30'b0, bus_sel}, 0);
        wait_until("wait_rd_0240", 0, 16'h0240);
        reg_wr = 1'b1; reg_data = 8'h07;
        @(negedge clk);
        reg_wr = 1'b0;
        wait_until("wait_idle_b", 2, 16'h0000);
        chk("steal_done_cnt", done_cnt, 2);
        chk("steal_sb_empty", sb.size(), 0);

        // reset abort at idx $80
        for (int i = 0; i < 128; i++) begin
            push_rd(8'h03, i[7:0]);
            push_wr(i[7:0]);
        end
        push_rd(8'h03, 8'h80);
        @(negedge clk);
        reg_wr = 1'b1; reg_data = 8'h03;
        @(negedge clk);
        reg_wr = 1'b0;
        wait_until("wait_rd_0380", 0, 16'h0380);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_halt", {31'b0, halt}, 0);
        chk("abort_sel", {30'b0, bus_sel}, 0);
        chk("abort_busy", {31'b0, busy}, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_idle_busy", {31'b0, busy}, 0);
        chk("abort_done_cnt", done_cnt, 2);
        chk("abort_sb_empty", sb.size(), 0);

        // DMC-only fetch from IDLE
        push_dmc(16'h1234);
        dmc_req = 1'b1; dmc_addr = 16'h1234;
        @(negedge clk);
        chk("dmc_only_busy", {31'b0, busy}, 1);
        wait_until("wait_ack_d", 1, 16'h0000);
        dmc_req = 1'b0;
        wait_until("wait_idle_d", 2, 16'h0000);
        chk("dmc_only_done_cnt", done_cnt, 2);
        chk("dmc_only_sb_empty", sb.size(), 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
